// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter that drives the 4:1 mux selects, holding them until the consumer accepts.
// Optional grant timeout is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_mux_sel_arbiter #(
   parameter int GUARD_CYCLES   = 1,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       out_ready,
   output logic       s0,
   output logic       s1,
   output logic [3:0] grant,
   output logic       sel_valid,
   output logic       xfer,
   output logic       timeout
);

   // state | meaning
   // IDLE  | evaluating requests, no grant outstanding
   // GRANT | one source granted, selects held until accepted or withdrawn
   // GUARD | dead cycles after a transfer, requests ignored
   typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

   state_t     state;
   logic [1:0] ptr;
   logic [1:0] idx;
   logic [1:0] pick;
   logic [1:0] cand;
   logic [3:0] guard_cnt;
`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;
`endif

   // Search ptr+1 .. ptr+4; iterating backwards lets the nearest requester win.
   always_comb begin
      pick = 2'd0;
      cand = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) pick = cand;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd3;
         idx       <= 2'd0;
         guard_cnt <= 4'd0;
         s0        <= 1'b0;
         s1        <= 1'b0;
         grant     <= 4'b0000;
         sel_valid <= 1'b0;
         xfer      <= 1'b0;
         timeout   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
         wait_cnt  <= 8'd0;
`endif
      end else begin
         xfer    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  idx       <= pick;
                  s1        <= pick[1];
                  s0        <= pick[0];
                  grant     <= 4'b0001 << pick;
                  sel_valid <= 1'b1;
                  state     <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                  wait_cnt  <= 8'd0;
`endif
               end
            end
            GRANT: begin
               if (out_ready) begin
                  xfer      <= 1'b1;
                  ptr       <= idx;
                  grant     <= 4'b0000;
                  sel_valid <= 1'b0;
                  if (GUARD_CYCLES > 0) begin
                     state     <= GUARD;
                     guard_cnt <= 4'(GUARD_CYCLES - 1);
                  end else begin
                     state <= IDLE;
                  end
               end else if (!req[idx]) begin
                  // Source gave up before acceptance: no transfer, priority unchanged.
                  grant     <= 4'b0000;
                  sel_valid <= 1'b0;
                  state     <= IDLE;
`ifdef RR_ARB_TIMEOUT_EN
               end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  // Stuck source is treated as served so it drops to lowest priority.
                  timeout   <= 1'b1;
                  ptr       <= idx;
                  grant     <= 4'b0000;
                  sel_valid <= 1'b0;
                  if (GUARD_CYCLES > 0) begin
                     state     <= GUARD;
                     guard_cnt <= 4'(GUARD_CYCLES - 1);
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
`endif
               end
            end
            GUARD: begin
               if (guard_cnt == 4'd0) state <= IDLE;
               else                   guard_cnt <= guard_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Upstream control stage for the 4:1 mux.
- Arbitrates round-robin among four requesting sources and drives the mux select lines s1/s0.
- Grant and select are held stable until the downstream consumer accepts the muxed data.
- After each accepted transfer, an optional guard gap is inserted before the next grant.

Parameters:
- GUARD_CYCLES, 1: dead cycles after each accepted transfer before re-arbitration (0..15).
- TIMEOUT_CYCLES, 8: max cycles a grant waits for out_ready; used only with RR_ARB_TIMEOUT_EN (1..255).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  per-source request, bit n = mux input in
- out_ready  input  1  downstream consumer accepts the muxed value this cycle
- s0  output  1  mux select LSB
- s1  output  1  mux select MSB
- grant  output  4  one-hot grant, bit n matches {s1,s0}=n
- sel_valid  output  1  s1/s0/grant valid; mux output y is meaningful
- xfer  output  1  one-cycle pulse: transfer accepted (sel_valid && out_ready)
- timeout  output  1  one-cycle pulse on grant abort (only with RR_ARB_TIMEOUT_EN, else tied 0)

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: s1=0, s0=0, grant=0000, sel_valid=0, xfer=0, timeout=0. State=IDLE. Last-served pointer ptr=3, so ch0 has first priority. Guard counter=0.
- Reset asserted mid-grant or mid-guard: abort immediately on that edge, no xfer pulse, all values return to reset values.
- States: IDLE, GRANT, GUARD.
- IDLE:
  - If req!=0, select the first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next edge: grant=onehot(idx), {s1,s0}=idx, sel_valid=1, go to GRANT.
  - Latency: req seen at edge k -> sel_valid at edge k+1.
- GRANT: s1/s0/grant held constant.
  - out_ready=1: xfer=1 next cycle, ptr<=idx, sel_valid/grant cleared. Go to GUARD if GUARD_CYCLES>0, else IDLE.
  - req[idx] drops with out_ready=0: grant withdrawn next edge (no xfer), ptr unchanged, go to IDLE.
  - req[idx] drops and out_ready=1 in the same cycle: counts as a transfer.
- GUARD:
  - Counter loads GUARD_CYCLES-1 on entry and decrements each cycle; go to IDLE when it reaches 0. Total gap between sel_valid falling and the next IDLE evaluation is GUARD_CYCLES cycles.
  - req is ignored during GUARD.
- GUARD_CYCLES=0: back-to-back grants every 2 cycles (IDLE evaluation, then GRANT).
- s1/s0 keep their last value while sel_valid=0. They change only when a new grant is issued, which avoids mux glitch activity.
- Pointer is 2 bits; wrap from 3 to 0 is natural modulo.
- Invariant: grant is always one-hot or zero, and grant!=0 iff sel_valid=1.

Optional Feature:
- Macro RR_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter clears on entry to GRANT and increments each GRANT cycle with out_ready=0.
  - When it reaches TIMEOUT_CYCLES: grant withdrawn next edge, timeout=1 for one cycle, ptr<=idx so the stuck source loses priority, go to GUARD (or IDLE if GUARD_CYCLES=0).
  - out_ready=1 on the same cycle as the limit counts as a transfer, not a timeout.
- Undefined: no counter, timeout tied 0, a grant waits indefinitely.

Test Plan:
- Reset then req=0101, out_ready=1 always, GUARD_CYCLES=1: grants ch0 ({s1,s0}=00), then ch2 (10), then ch0. One xfer per grant, one idle gap between grants.
- req=1111 held, out_ready=1: grant sequence 0,1,2,3,0. s1/s0 sequence 00,01,10,11,00. Mux inputs i0..i3=1,0,1,0 give y=1,0,1,0,1 at each xfer.
- req=0010, out_ready=0 for 5 cycles then 1: sel_valid high 6 cycles, s1s0=01 stable throughout, single xfer pulse.
- req=1000 granted, then req[3] drops with out_ready=0: grant=0000 next cycle, no xfer. Next req=1001 grants ch0 first (ptr still 3).
- Assert rst during GRANT of ch2: next cycle all outputs at reset values. Following req=0100 grants ch2 with latency 1.
- With RR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, req=0001, out_ready=0: timeout pulse after 4 GRANT cycles, grant cleared, no xfer. With req=0011, ch1 is granted next.
